lib_wormhole_output_arbiter: RTL and testbench
==============================================

// Module: lib_wormhole_output_arbiter
// PURPOSE
//  Wormhole output-port arbiter for a router: N input ports compete for one output link. Round-robin
//  selection at packet boundaries; grant held from head to tail flit so packets never interleave.
//  Flits forwarded only while downstream credits remain. One instance per router output port.
// PARAMETERS
//  N        4   number of input requesters (N >= 2)
//  CREDITS  4   downstream buffer depth; credit counter reset value (CREDITS >= 1)
//  CW       $clog2(CREDITS+1)  credit counter width (derived, localparam)
//  IW       $clog2(N)          owner index width (derived, localparam)
// PORTS
//  clk            in   1    clock
//  reset_n        in   1    synchronous, active-low reset
//  i_valid        in   N    [0:N-1] flit present at head of input i
//  i_tail         in   N    [0:N-1] flit at head of input i is a tail (head+tail = single-flit pkt)
//  i_credit_ret   in   1    downstream freed one buffer slot this cycle
//  o_grant        out  N    [0:N-1] one-hot/zero; flit of input i is popped and sent this cycle
//  o_sel          out  IW   index of granted input (mux select); 0 when no grant
//  o_out_valid    out  1    |o_grant; flit on output link this cycle
//  o_locked       out  1    registered; 1 while a multi-flit packet owns the output
//  o_credits      out  CW   registered current credit count
//  o_credit_err   out  1    sticky; credit returned while counter already at CREDITS
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, priority one-hot = input 0, owner=0, credits=CREDITS,
//   o_credit_err=0, o_locked=0. o_grant/o_sel/o_out_valid combinational; 0 while i_valid=0.
//  Grant is combinational, zero latency: flit accepted in the cycle o_grant[i]=1.
//  No grant of any kind while credits==0 (credit returned same cycle does not enable grant).
//  FSM IDLE:
//   - credits>0 & |i_valid: grant first valid input at or after priority pointer, wrapping N-1 -> 0.
//   - granted flit i_tail=1: stay IDLE, priority <= one-hot(i+1 mod N).
//   - granted flit i_tail=0: -> LOCKED, owner <= i, priority unchanged.
//  FSM LOCKED:
//   - only owner may be granted: o_grant[owner]=i_valid[owner] & credits>0; other inputs ignored.
//   - owner bubble (i_valid[owner]=0) holds lock; output idle that cycle.
//   - granted flit with i_tail=1: -> IDLE, priority <= one-hot(owner+1 mod N).
//  Priority changes only on tail grant; unchanged in idle cycles and bubbles.
//  Credit counter, per cycle: grant & ~ret -> -1; ret & ~grant -> +1; both -> unchanged.
//   ret with credits==CREDITS and no grant -> counter saturates, o_credit_err <= 1 (cleared only by reset).
//   Counter never underflows (grant impossible at 0).
//  Reset mid-packet: lock dropped, owner discarded, credits restored; next cycle behaves as IDLE.
//  Invariants (assert): $onehot0(o_grant); o_grant implies matching i_valid; credits <= CREDITS.
// TESTING
//  1 Reset, i_valid=4'b1111, all tails, credits ample, ret every cycle -> grants in order 0,1,2,3,0.
//  2 Input 2 sends 3-flit pkt (tail on 3rd), input 0 valid throughout -> o_grant=0010 x3, o_locked=1
//    cycles 1-2 after first grant, then input 3 skipped if idle, input 0 granted next; priority=3 after.
//  3 CREDITS=4, no ret, input 1 streams 6 single-flit pkts -> exactly 4 grants, o_credits 4,3,2,1,0,
//    o_out_valid=0 thereafter; one ret pulse -> exactly one further grant.
//  4 credits=2, grant and ret in same cycle -> o_credits stays 2; ret at credits=4 no grant ->
//    o_credits=4, o_credit_err=1 and stays 1.
//  5 Locked to input 1, i_valid[1]=0 two cycles, i_valid[3]=1 -> no grants, o_locked=1; input 1 tail
//    then granted -> input 3 granted next cycle.
//  6 reset_n=0 one cycle mid-packet of input 2 with credits=1 -> o_locked=0, o_credits=4, priority=0;
//    next cycle i_valid=0110 -> input 1 granted.

Source files
------------

// File: rtl/lib_wormhole_output_arbiter.sv
// Wormhole output-port arbiter: round-robin at packet boundaries, grant held head-to-tail,
// flits forwarded only while downstream credits remain.
module lib_wormhole_output_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned CREDITS = 4,
    localparam int unsigned CW     = $clog2(CREDITS + 1),
    localparam int unsigned IW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [0:N-1]  i_valid,
    input  logic [0:N-1]  i_tail,
    input  logic          i_credit_ret,
    output logic [0:N-1]  o_grant,
    output logic [IW-1:0] o_sel,
    output logic          o_out_valid,
    output logic          o_locked,
    output logic [CW-1:0] o_credits,
    output logic          o_credit_err
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [0:N-1] PRIO_RST = {1'b1, {(N - 1){1'b0}}};

    state_t        state_q, state_d;
    logic [0:N-1]  prio_q, prio_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          err_q, err_d;

    logic [0:N-1]  grant;
    logic [IW-1:0] sel;
    logic [IW-1:0] ptr;
    logic          found;
    int unsigned   idx;
    int unsigned   nxt;

    // Grant selection: owner only while locked, else first valid input from the pointer
    always_comb begin
        ptr   = '0;
        grant = '0;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (prio_q[i]) ptr = IW'(i);
        end
        if (cred_q != '0) begin
            if (state_q == S_LOCKED) begin
                if (i_valid[owner_q]) begin
                    found = 1'b1;
                    sel   = owner_q;
                end
            end else begin
                for (int unsigned k = 0; k < N; k++) begin
                    idx = (32'(ptr) + k) % N;
                    if (!found && i_valid[idx]) begin
                        found = 1'b1;
                        sel   = IW'(idx);
                    end
                end
            end
        end
        if (found) grant[sel] = 1'b1;
    end

    // Next state: lock on non-tail grant, release and rotate priority on tail grant
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        cred_d  = cred_q;
        err_d   = err_q;
        nxt     = 0;
        if (found) begin
            nxt = (32'(sel) + 1) % N;
            if (i_tail[sel]) begin
                state_d     = S_IDLE;
                prio_d      = '0;
                prio_d[nxt] = 1'b1;
            end else if (state_q == S_IDLE) begin
                state_d = S_LOCKED;
                owner_d = sel;
            end
        end
        if (found && !i_credit_ret) begin
            cred_d = cred_q - CW'(1);
        end else if (!found && i_credit_ret) begin
            if (cred_q == CW'(CREDITS)) err_d = 1'b1;
            else                        cred_d = cred_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            prio_q  <= PRIO_RST;
            owner_q <= '0;
            cred_q  <= CW'(CREDITS);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert ($onehot0(grant));
            assert ((grant & ~i_valid) == '0);
            assert (cred_q <= CW'(CREDITS));
        end
    end

    assign o_grant      = grant;
    assign o_sel        = sel;
    assign o_out_valid  = found;
    assign o_locked     = (state_q == S_LOCKED);
    assign o_credits    = cred_q;
    assign o_credit_err = err_q;

endmodule

// File: tb/tb_lib_wormhole_output_arbiter.sv
// Bench for lib_wormhole_output_arbiter: directed scenarios plus random traffic,
// checked each cycle against a packet-level reference model.
module tb_lib_wormhole_output_arbiter;

    localparam int N       = 4;
    localparam int CREDITS = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [0:N-1] i_valid;
    logic [0:N-1] i_tail;
    logic         i_credit_ret;
    logic [0:N-1] o_grant;
    logic [1:0]   o_sel;
    logic         o_out_valid;
    logic         o_locked;
    logic [2:0]   o_credits;
    logic         o_credit_err;

    lib_wormhole_output_arbiter #(.N(N), .CREDITS(CREDITS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_valid      (i_valid),
        .i_tail       (i_tail),
        .i_credit_ret (i_credit_ret),
        .o_grant      (o_grant),
        .o_sel        (o_sel),
        .o_out_valid  (o_out_valid),
        .o_locked     (o_locked),
        .o_credits    (o_credits),
        .o_credit_err (o_credit_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    int m_prio, m_owner, m_cred, last_g;
    bit m_locked, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0; m_owner = 0; m_cred = CREDITS; m_locked = 0; m_err = 0;
    endtask

    task automatic do_reset(input logic [0:N-1] v, input logic [0:N-1] t);
        i_valid = v; i_tail = t; i_credit_ret = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic do_cycle(input string tag, input logic [0:N-1] v, input logic [0:N-1] t,
                            input logic r);
        int g;
        logic [0:N-1] eg;
        i_valid = v; i_tail = t; i_credit_ret = r;
        #2;
        g = -1;
        if (m_cred > 0) begin
            if (m_locked) begin
                if (v[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && v[(m_prio + k) % N]) g = (m_prio + k) % N;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk({tag, ".grant"},   32'(o_grant),      32'(eg));
        chk({tag, ".sel"},     32'(o_sel),        32'((g >= 0) ? g : 0));
        chk({tag, ".valid"},   32'(o_out_valid),  32'(g >= 0));
        chk({tag, ".locked"},  32'(o_locked),     32'(m_locked));
        chk({tag, ".credits"}, 32'(o_credits),    32'(m_cred));
        chk({tag, ".err"},     32'(o_credit_err), 32'(m_err));
        last_g = g;
        @(posedge clk); #1;
        if (g >= 0) begin
            if (t[g]) begin
                m_locked = 0;
                m_prio   = (g + 1) % N;
            end else begin
                m_locked = 1;
                m_owner  = g;
            end
        end
        if (g >= 0 && !r)      m_cred--;
        else if (g < 0 && r) begin
            if (m_cred == CREDITS) m_err = 1;
            else                   m_cred++;
        end
    endtask

    int exp1 [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset_n = 1'b0; i_valid = '0; i_tail = '0; i_credit_ret = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: round robin over single-flit packets
        do_reset('0, '0);
        for (int i = 0; i < 5; i++) begin
            do_cycle($sformatf("t1.%0d", i), 4'b1111, 4'b1111, 1'b1);
            chk($sformatf("t1.order%0d", i), 32'(last_g), 32'(exp1[i]));
        end

        // 2: three-flit packet from input 2 holds off input 0
        do_reset('0, '0);
        do_cycle("t2.p0", 4'b1000, 4'b1000, 1'b1);
        do_cycle("t2.p1", 4'b0100, 4'b0100, 1'b1);
        do_cycle("t2.f0", 4'b1010, 4'b0000, 1'b1);
        chk("t2.f0sel", 32'(last_g), 32'd2);
        do_cycle("t2.f1", 4'b1010, 4'b0000, 1'b1);
        chk("t2.f1lock", 32'(o_locked), 32'd1);
        do_cycle("t2.f2", 4'b1010, 4'b0010, 1'b1);
        chk("t2.f2sel", 32'(last_g), 32'd2);
        do_cycle("t2.nx", 4'b1000, 4'b1000, 1'b1);
        chk("t2.nxsel", 32'(last_g), 32'd0);

        // 3: credit exhaustion then one return
        do_reset('0, '0);
        for (int i = 0; i < 6; i++) begin
            do_cycle($sformatf("t3.%0d", i), 4'b0100, 4'b0100, 1'b0);
            chk($sformatf("t3.v%0d", i), 32'(last_g >= 0), 32'(i < 4));
        end
        do_cycle("t3.ret", 4'b0100, 4'b0100, 1'b1);
        chk("t3.retnogrant", 32'(last_g), 32'hFFFF_FFFF);
        do_cycle("t3.g1", 4'b0100, 4'b0100, 1'b0);
        chk("t3.g1sel", 32'(last_g), 32'd1);
        do_cycle("t3.g2", 4'b0100, 4'b0100, 1'b0);
        chk("t3.g2none", 32'(o_out_valid), 32'd0);

        // 4: simultaneous grant/return, then overflow error is sticky
        do_reset('0, '0);
        do_cycle("t4.a", 4'b1000, 4'b1000, 1'b0);
        do_cycle("t4.b", 4'b1000, 4'b1000, 1'b0);
        do_cycle("t4.c", 4'b1000, 4'b1000, 1'b1);
        chk("t4.cred2", 32'(o_credits), 32'd2);
        do_cycle("t4.r1", 4'b0000, 4'b0000, 1'b1);
        do_cycle("t4.r2", 4'b0000, 4'b0000, 1'b1);
        do_cycle("t4.r3", 4'b0000, 4'b0000, 1'b1);
        do_cycle("t4.idle", 4'b0000, 4'b0000, 1'b0);
        chk("t4.errstick", 32'(o_credit_err), 32'd1);
        chk("t4.credfull", 32'(o_credits), 32'd4);

        // 5: owner bubble holds lock, other requester waits
        do_reset('0, '0);
        do_cycle("t5.h", 4'b0100, 4'b0000, 1'b1);
        do_cycle("t5.b0", 4'b0001, 4'b0000, 1'b1);
        do_cycle("t5.b1", 4'b0001, 4'b0000, 1'b1);
        chk("t5.bubble", 32'(last_g), 32'hFFFF_FFFF);
        do_cycle("t5.t", 4'b0101, 4'b0100, 1'b1);
        chk("t5.tail", 32'(last_g), 32'd1);
        do_cycle("t5.n", 4'b0001, 4'b0001, 1'b1);
        chk("t5.next", 32'(last_g), 32'd3);

        // 6: reset mid-packet with one credit left
        do_reset('0, '0);
        do_cycle("t6.h", 4'b0010, 4'b0000, 1'b0);
        do_cycle("t6.b", 4'b0010, 4'b0000, 1'b0);
        do_cycle("t6.c", 4'b0010, 4'b0000, 1'b0);
        chk("t6.cred1", 32'(o_credits), 32'd1);
        do_reset(4'b0010, 4'b0000);
        chk("t6.rlock", 32'(o_locked), 32'd0);
        chk("t6.rcred", 32'(o_credits), 32'd4);
        do_cycle("t6.n", 4'b0110, 4'b0110, 1'b0);
        chk("t6.nsel", 32'(last_g), 32'd1);

        // random traffic with occasional resets
        do_reset('0, '0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset(4'($urandom), 4'($urandom));
            else
                do_cycle($sformatf("rnd.%0d", i), 4'($urandom), 4'($urandom & $urandom),
                         1'($urandom_range(0, 99) < 45));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
